// File: rtl/tlb_sweep.sv
// Multi-port TLB with 1-cycle registered search/read, pseudo-random fill index,
// and an INVTLB engine that sweeps one entry per cycle.
module tlb_sweep #(
    parameter int TLBNUM = 16,
    parameter int NSRCH  = 2,
    localparam int IW    = $clog2(TLBNUM)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [NSRCH*19-1:0]   s_vppn,
    input  logic [NSRCH-1:0]      s_va_bit12,
    input  logic [NSRCH*10-1:0]   s_asid,
    output logic [NSRCH-1:0]      s_found,
    output logic [NSRCH-1:0]      s_multi,
    output logic [NSRCH*IW-1:0]   s_index,
    output logic [NSRCH*32-1:0]   s_pte,
    input  logic                  we,
    input  logic [IW-1:0]         w_index,
    input  logic [88:0]           w_entry,
    input  logic [IW-1:0]         r_index,
    output logic [88:0]           r_entry,
    input  logic                  inv_valid,
    output logic                  inv_ready,
    input  logic [4:0]            inv_op,
    input  logic [9:0]            inv_asid,
    input  logic [18:0]           inv_vppn,
    output logic                  inv_done,
    output logic                  inv_err,
    output logic [IW-1:0]         fill_index
);

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} inv_state_t;

    localparam logic [5:0] PS_4M = 6'd21;

    // Entry body (everything but e): vppn[87:69] ps[68:63] asid[62:53] g[52]
    // even half [51:26], odd half [25:0]; each half is {ppn, plv, mat, d, v}.
    logic [TLBNUM-1:0] tlb_e;
    logic [87:0]       tlb_d [TLBNUM];

    inv_state_t    state_q, state_d;
    logic [IW-1:0] ptr_q;
    logic [4:0]    op_q;
    logic [9:0]    asid_q;
    logic [18:0]   vppn_q;
    logic          err_q;
    logic          accept;
    logic          sweep_clr;

    logic [NSRCH-1:0]    found_c;
    logic [NSRCH-1:0]    multi_c;
    logic [NSRCH*IW-1:0] index_c;
    logic [NSRCH*32-1:0] pte_c;

    function automatic logic va_match(input logic [87:0] d, input logic [18:0] vppn);
        va_match = (d[87:78] == vppn[18:9]) &&
                   ((d[68:63] == PS_4M) || (d[77:69] == vppn[8:0]));
    endfunction

    function automatic logic [31:0] pte_of(input logic [87:0] d, input logic odd);
        logic [25:0] half;
        half   = odd ? d[25:0] : d[51:26];
        pte_of = {half[25:6], d[68:63], half[5:0]};
    endfunction

    function automatic logic inv_hit(input logic [4:0] op, input logic [87:0] d,
                                     input logic [9:0] asid, input logic [18:0] vppn);
        logic g;
        logic asid_eq;
        g       = d[52];
        asid_eq = (d[62:53] == asid);
        case (op)
            5'd0, 5'd1: inv_hit = 1'b1;
            5'd2:       inv_hit = g;
            5'd3:       inv_hit = !g;
            5'd4:       inv_hit = !g && asid_eq;
            5'd5:       inv_hit = !g && asid_eq && va_match(d, vppn);
            5'd6:       inv_hit = (g || asid_eq) && va_match(d, vppn);
            default:    inv_hit = 1'b0;
        endcase
    endfunction

    // Search: lowest matching index wins, later matches only raise multi.
    always_comb begin
        found_c = '0;
        multi_c = '0;
        index_c = '0;
        pte_c   = '0;
        for (int p = 0; p < NSRCH; p++) begin
            for (int i = 0; i < TLBNUM; i++) begin
                if (tlb_e[i] && va_match(tlb_d[i], s_vppn[p*19 +: 19]) &&
                    (tlb_d[i][52] || (tlb_d[i][62:53] == s_asid[p*10 +: 10]))) begin
                    if (found_c[p]) begin
                        multi_c[p] = 1'b1;
                    end else begin
                        found_c[p]           = 1'b1;
                        index_c[p*IW +: IW]  = IW'(i);
                        pte_c[p*32 +: 32]    = pte_of(tlb_d[i],
                            (tlb_d[i][68:63] == PS_4M) ? s_vppn[p*19+8] : s_va_bit12[p]);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s_found <= '0;
            s_multi <= '0;
            s_index <= '0;
            s_pte   <= '0;
            r_entry <= '0;
        end else begin
            s_found <= found_c;
            s_multi <= multi_c;
            s_index <= index_c;
            s_pte   <= pte_c;
            r_entry <= {tlb_e[r_index], tlb_d[r_index]};
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            tlb_d[w_index] <= w_entry[87:0];
        end
    end

    // A same-cycle write to the swept entry overrides the clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tlb_e <= '0;
        end else begin
            if (sweep_clr) begin
                tlb_e[ptr_q] <= 1'b0;
            end
            if (we) begin
                tlb_e[w_index] <= w_entry[88];
            end
        end
    end

    assign accept    = inv_valid && inv_ready;
    assign sweep_clr = (state_q == SWEEP) && inv_hit(op_q, tlb_d[ptr_q], asid_q, vppn_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (inv_valid) begin
                    state_d = (inv_op <= 5'd6) ? SWEEP : DONE;
                end
            end
            SWEEP: begin
                if (ptr_q == IW'(TLBNUM - 1)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            err_q      <= 1'b0;
            fill_index <= '0;
        end else begin
            state_q    <= state_d;
            fill_index <= fill_index + 1'b1;
            if (accept) begin
                ptr_q <= '0;
                err_q <= (inv_op > 5'd6);
            end else if (state_q == SWEEP) begin
                ptr_q <= ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_q   <= inv_op;
            asid_q <= inv_asid;
            vppn_q <= inv_vppn;
        end
    end

    assign inv_ready = (state_q == IDLE);
    assign inv_done  = (state_q == DONE);
    assign inv_err   = (state_q == DONE) && err_q;

endmodule

// File: tb/tb_tlb_sweep.sv
// Directed bench for tlb_sweep: search, read, INVTLB sweep, fill counter, reset.
module tb_tlb_sweep;

    localparam int TLBNUM = 16;
    localparam int NSRCH  = 2;
    localparam int IW     = 4;

    logic                clk = 1'b0;
    logic                resetn;
    logic [NSRCH*19-1:0] s_vppn;
    logic [NSRCH-1:0]    s_va_bit12;
    logic [NSRCH*10-1:0] s_asid;
    logic [NSRCH-1:0]    s_found;
    logic [NSRCH-1:0]    s_multi;
    logic [NSRCH*IW-1:0] s_index;
    logic [NSRCH*32-1:0] s_pte;
    logic                we;
    logic [IW-1:0]       w_index;
    logic [88:0]         w_entry;
    logic [IW-1:0]       r_index;
    logic [88:0]         r_entry;
    logic                inv_valid;
    logic                inv_ready;
    logic [4:0]          inv_op;
    logic [9:0]          inv_asid;
    logic [18:0]         inv_vppn;
    logic                inv_done;
    logic                inv_err;
    logic [IW-1:0]       fill_index;

    int total = 0;
    int bad   = 0;

    logic [88:0] e3, e4, e7, em, e15, e5, exp_e;

    always #5 clk = ~clk;

    tlb_sweep #(.TLBNUM(TLBNUM), .NSRCH(NSRCH)) dut (
        .clk(clk), .resetn(resetn),
        .s_vppn(s_vppn), .s_va_bit12(s_va_bit12), .s_asid(s_asid),
        .s_found(s_found), .s_multi(s_multi), .s_index(s_index), .s_pte(s_pte),
        .we(we), .w_index(w_index), .w_entry(w_entry),
        .r_index(r_index), .r_entry(r_entry),
        .inv_valid(inv_valid), .inv_ready(inv_ready), .inv_op(inv_op),
        .inv_asid(inv_asid), .inv_vppn(inv_vppn),
        .inv_done(inv_done), .inv_err(inv_err), .fill_index(fill_index)
    );

    function automatic logic [88:0] mk(input logic e, input logic [18:0] vppn,
                                       input logic [5:0] ps, input logic [9:0] asid,
                                       input logic g, input logic [19:0] ppn0,
                                       input logic [5:0] lo0, input logic [19:0] ppn1,
                                       input logic [5:0] lo1);
        return {e, vppn, ps, asid, g, ppn0, lo0, ppn1, lo1};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [IW-1:0] idx, input logic [88:0] ent);
        we = 1'b1; w_index = idx; w_entry = ent;
        tick();
        we = 1'b0;
    endtask

    task automatic srch(input int p, input logic [18:0] vppn, input logic [9:0] asid,
                        input logic b12);
        s_vppn[p*19 +: 19] = vppn;
        s_asid[p*10 +: 10] = asid;
        s_va_bit12[p]      = b12;
    endtask

    task automatic rd(input logic [IW-1:0] idx);
        r_index = idx;
        tick();
    endtask

    task automatic test_reset();
        #1 resetn = 1'b0;
        #1;
        total++; if (inv_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got %b want 1", inv_ready); end
        total++; if (inv_done !== 1'b0) begin bad++; $display("FAIL rst_done got %b want 0", inv_done); end
        total++; if (s_found !== 2'b00 || s_index !== 8'h00 || s_pte !== 64'h0) begin
            bad++; $display("FAIL rst_search got %b %h %h want 0", s_found, s_index, s_pte); end
        total++; if (r_entry !== 89'h0) begin bad++; $display("FAIL rst_rentry got %h want 0", r_entry); end
        total++; if (fill_index !== 4'd0) begin bad++; $display("FAIL rst_fill got %0d want 0", fill_index); end
        tick();
        tick();
        total++; if (inv_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_held got %b want 1", inv_ready); end
        resetn = 1'b1;
    endtask

    task automatic test_fill();
        tick();
        total++; if (fill_index !== 4'd1) begin bad++; $display("FAIL fill_1 got %0d want 1", fill_index); end
        repeat (14) tick();
        total++; if (fill_index !== 4'd15) begin bad++; $display("FAIL fill_15 got %0d want 15", fill_index); end
        tick();
        total++; if (fill_index !== 4'd0) begin bad++; $display("FAIL fill_wrap got %0d want 0", fill_index); end
        tick();
        total++; if (fill_index !== 4'd1) begin bad++; $display("FAIL fill_after_wrap got %0d want 1", fill_index); end
    endtask

    task automatic test_search_basic();
        wr(4'd3, e3);
        wr(4'd4, e4);
        srch(0, 19'h12345, 10'd5, 1'b0);
        srch(1, 19'h12345, 10'd5, 1'b1);
        tick();
        total++; if (s_found !== 2'b11 || s_multi !== 2'b00) begin
            bad++; $display("FAIL basic_found got %b/%b want 11/00", s_found, s_multi); end
        total++; if (s_index !== {4'd3, 4'd3}) begin bad++; $display("FAIL basic_index got %h want 33", s_index); end
        total++; if (s_pte[31:0] !== {20'hAAAAA, 6'd12, 6'b100111}) begin
            bad++; $display("FAIL basic_pte_even got %h want %h", s_pte[31:0], {20'hAAAAA, 6'd12, 6'b100111}); end
        total++; if (s_pte[63:32] !== {20'h33333, 6'd12, 6'b000001}) begin
            bad++; $display("FAIL basic_pte_odd got %h want %h", s_pte[63:32], {20'h33333, 6'd12, 6'b000001}); end
        srch(1, 19'h12345, 10'd6, 1'b0);
        tick();
        total++; if (s_found[1] !== 1'b0 || s_index[7:4] !== 4'd0 || s_pte[63:32] !== 32'h0) begin
            bad++; $display("FAIL asid_miss got %b %h %h want 0 0 0", s_found[1], s_index[7:4], s_pte[63:32]); end
    endtask

    task automatic test_4mb();
        wr(4'd7, e7);
        srch(0, 19'h001FF, 10'd9, 1'b0);
        srch(1, 19'h000FF, 10'd9, 1'b1);
        tick();
        total++; if (s_found !== 2'b11 || s_index !== {4'd7, 4'd7}) begin
            bad++; $display("FAIL big_hit got %b %h want 11 77", s_found, s_index); end
        total++; if (s_pte[31:0] !== {20'hBBBBB, 6'd21, 6'b000011}) begin
            bad++; $display("FAIL big_pte_odd got %h want %h", s_pte[31:0], {20'hBBBBB, 6'd21, 6'b000011}); end
        total++; if (s_pte[63:32] !== {20'h11111, 6'd21, 6'b000001}) begin
            bad++; $display("FAIL big_pte_even got %h want %h", s_pte[63:32], {20'h11111, 6'd21, 6'b000001}); end
    endtask

    task automatic test_multi();
        wr(4'd2, em);
        wr(4'd9, em);
        srch(0, 19'h05555, 10'h3FF, 1'b0);
        srch(1, 19'h05554, 10'd0, 1'b0);
        tick();
        total++; if (s_found !== 2'b01 || s_multi !== 2'b01) begin
            bad++; $display("FAIL multi_flags got %b/%b want 01/01", s_found, s_multi); end
        total++; if (s_index[3:0] !== 4'd2) begin bad++; $display("FAIL multi_index got %0d want 2", s_index[3:0]); end
        total++; if (s_pte[31:0] !== {20'h22222, 6'd12, 6'b000001}) begin
            bad++; $display("FAIL multi_pte got %h want %h", s_pte[31:0], {20'h22222, 6'd12, 6'b000001}); end
        total++; if (s_index[7:4] !== 4'd0 || s_pte[63:32] !== 32'h0) begin
            bad++; $display("FAIL miss_zero got %h %h want 0 0", s_index[7:4], s_pte[63:32]); end
    endtask

    task automatic test_read();
        rd(4'd3);
        total++; if (r_entry !== e3) begin bad++; $display("FAIL read3 got %h want %h", r_entry, e3); end
        rd(4'd7);
        total++; if (r_entry !== e7) begin bad++; $display("FAIL read7 got %h want %h", r_entry, e7); end
    endtask

    task automatic test_inv_op5();
        logic early;
        early = 1'b0;
        srch(0, 19'h12345, 10'd5, 1'b0);
        srch(1, 19'h00100, 10'd9, 1'b0);
        inv_op = 5'd5; inv_asid = 10'd5; inv_vppn = 19'h12345; inv_valid = 1'b1;
        total++; if (inv_ready !== 1'b1) begin bad++; $display("FAIL op5_ready got %b want 1", inv_ready); end
        tick();
        inv_op = 5'd9;
        total++; if (inv_ready !== 1'b0 || inv_done !== 1'b0) begin
            bad++; $display("FAIL op5_busy got rdy=%b done=%b want 0 0", inv_ready, inv_done); end
        tick();
        total++; if (s_found !== 2'b11) begin bad++; $display("FAIL op5_search_early got %b want 11", s_found); end
        for (int n = 3; n <= 16; n++) begin
            tick();
            early = early | inv_done;
            if (n == 8) begin
                total++; if (s_found !== 2'b10) begin
                    bad++; $display("FAIL op5_search_mid got %b want 10", s_found); end
            end
            if (n == 10) inv_valid = 1'b0;
        end
        total++; if (early !== 1'b0) begin bad++; $display("FAIL op5_early_done got %b want 0", early); end
        tick();
        total++; if (inv_done !== 1'b1 || inv_err !== 1'b0) begin
            bad++; $display("FAIL op5_done got done=%b err=%b want 1 0", inv_done, inv_err); end
        tick();
        total++; if (inv_done !== 1'b0 || inv_ready !== 1'b1) begin
            bad++; $display("FAIL op5_idle got done=%b rdy=%b want 0 1", inv_done, inv_ready); end
        inv_op = 5'd0;
        exp_e = e3; exp_e[88] = 1'b0;
        rd(4'd3);
        total++; if (r_entry !== exp_e) begin bad++; $display("FAIL op5_idx3 got %h want %h", r_entry, exp_e); end
        rd(4'd4);
        total++; if (r_entry !== e4) begin bad++; $display("FAIL op5_idx4 got %h want %h", r_entry, e4); end
        rd(4'd7);
        total++; if (r_entry !== e7) begin bad++; $display("FAIL op5_idx7 got %h want %h", r_entry, e7); end
        rd(4'd2);
        total++; if (r_entry !== em) begin bad++; $display("FAIL op5_idx2 got %h want %h", r_entry, em); end
    endtask

    task automatic test_inv_err();
        inv_op = 5'd9; inv_valid = 1'b1;
        total++; if (inv_ready !== 1'b1) begin bad++; $display("FAIL err_ready got %b want 1", inv_ready); end
        tick();
        inv_valid = 1'b0;
        total++; if (inv_done !== 1'b1 || inv_err !== 1'b1) begin
            bad++; $display("FAIL err_done got done=%b err=%b want 1 1", inv_done, inv_err); end
        tick();
        total++; if (inv_done !== 1'b0 || inv_err !== 1'b0 || inv_ready !== 1'b1) begin
            bad++; $display("FAIL err_idle got %b%b%b want 001", inv_done, inv_err, inv_ready); end
        rd(4'd4);
        total++; if (r_entry !== e4) begin bad++; $display("FAIL err_table got %h want %h", r_entry, e4); end
        total++; if (s_found[1] !== 1'b1 || s_index[7:4] !== 4'd7) begin
            bad++; $display("FAIL err_search got %b %0d want 1 7", s_found[1], s_index[7:4]); end
        inv_op = 5'd0;
    endtask

    task automatic test_inv_op2();
        logic early;
        early = 1'b0;
        wr(4'd15, e15);
        inv_op = 5'd2; inv_valid = 1'b1;
        tick();
        inv_valid = 1'b0;
        for (int n = 2; n <= 16; n++) begin
            tick();
            early = early | inv_done;
        end
        tick();
        total++; if (early !== 1'b0 || inv_done !== 1'b1) begin
            bad++; $display("FAIL op2_timing got early=%b done=%b want 0 1", early, inv_done); end
        rd(4'd15);
        total++; if (r_entry[88] !== 1'b0) begin bad++; $display("FAIL op2_idx15 got e=%b want 0", r_entry[88]); end
        rd(4'd9);
        total++; if (r_entry[88] !== 1'b0) begin bad++; $display("FAIL op2_idx9 got e=%b want 0", r_entry[88]); end
        rd(4'd7);
        total++; if (r_entry !== e7) begin bad++; $display("FAIL op2_idx7 got %h want %h", r_entry, e7); end
        rd(4'd4);
        total++; if (r_entry !== e4) begin bad++; $display("FAIL op2_idx4 got %h want %h", r_entry, e4); end
        inv_op = 5'd0;
    endtask

    task automatic test_write_wins();
        inv_op = 5'd0; inv_valid = 1'b1;
        tick();
        inv_valid = 1'b0;
        for (int n = 2; n <= 6; n++) tick();
        we = 1'b1; w_index = 4'd5; w_entry = e5;
        tick();
        we = 1'b0;
        for (int n = 8; n <= 16; n++) tick();
        tick();
        total++; if (inv_done !== 1'b1) begin bad++; $display("FAIL op0_done got %b want 1", inv_done); end
        rd(4'd5);
        total++; if (r_entry !== e5) begin bad++; $display("FAIL wr_wins got %h want %h", r_entry, e5); end
        rd(4'd7);
        total++; if (r_entry[88] !== 1'b0) begin bad++; $display("FAIL op0_idx7 got e=%b want 0", r_entry[88]); end
        rd(4'd4);
        total++; if (r_entry[88] !== 1'b0) begin bad++; $display("FAIL op0_idx4 got e=%b want 0", r_entry[88]); end
    endtask

    task automatic test_reset_mid_sweep();
        logic seen;
        seen = 1'b0;
        wr(4'd7, e7);
        srch(1, 19'h00100, 10'd9, 1'b0);
        inv_op = 5'd3; inv_valid = 1'b1;
        tick();
        inv_valid = 1'b0;
        repeat (4) tick();
        total++; if (inv_ready !== 1'b0) begin bad++; $display("FAIL mid_busy got %b want 0", inv_ready); end
        resetn = 1'b0;
        #1;
        total++; if (inv_ready !== 1'b1 || inv_done !== 1'b0) begin
            bad++; $display("FAIL mid_rst_fsm got rdy=%b done=%b want 1 0", inv_ready, inv_done); end
        total++; if (fill_index !== 4'd0 || s_found !== 2'b00 || r_entry !== 89'h0) begin
            bad++; $display("FAIL mid_rst_regs got %0d %b %h want 0 0 0", fill_index, s_found, r_entry); end
        tick();
        resetn = 1'b1;
        r_index = 4'd5;
        for (int n = 0; n < 20; n++) begin
            tick();
            seen = seen | inv_done;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL mid_no_done got %b want 0", seen); end
        total++; if (r_entry[88] !== 1'b0) begin bad++; $display("FAIL mid_idx5 got e=%b want 0", r_entry[88]); end
        total++; if (s_found[1] !== 1'b0) begin bad++; $display("FAIL mid_idx7 got %b want 0", s_found[1]); end
        total++; if (inv_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got %b want 1", inv_ready); end
    endtask

    initial begin
        resetn = 1'b1;
        s_vppn = '0; s_va_bit12 = '0; s_asid = '0;
        we = 1'b0; w_index = '0; w_entry = '0; r_index = '0;
        inv_valid = 1'b0; inv_op = '0; inv_asid = '0; inv_vppn = '0;
        e3  = mk(1'b1, 19'h12345, 6'd12, 10'd5, 1'b0, 20'hAAAAA, 6'b100111, 20'h33333, 6'b000001);
        e4  = mk(1'b1, 19'h12346, 6'd12, 10'd5, 1'b0, 20'h44444, 6'b000001, 20'h44445, 6'b000001);
        e7  = mk(1'b1, 19'h00100, 6'd21, 10'd9, 1'b0, 20'h11111, 6'b000001, 20'hBBBBB, 6'b000011);
        em  = mk(1'b1, 19'h05555, 6'd12, 10'd0, 1'b1, 20'h22222, 6'b000001, 20'h22223, 6'b000001);
        e15 = mk(1'b1, 19'h7FFFF, 6'd12, 10'd0, 1'b1, 20'h55555, 6'b000001, 20'h55556, 6'b000001);
        e5  = mk(1'b1, 19'h00005, 6'd12, 10'd1, 1'b0, 20'h66666, 6'b000001, 20'h66667, 6'b000001);
        test_reset();
        test_fill();
        test_search_basic();
        test_4mb();
        test_multi();
        test_read();
        test_inv_op5();
        test_inv_err();
        test_inv_op2();
        test_write_wins();
        test_reset_mid_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
